// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq_ctrl
// Purpose  : Clears an N x N systolic MAC array, then feeds it K skewed operand
//            pairs per row and column, drains it and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    output logic            busy,
    output logic            done,
    output logic            arr_nreset,
    output logic            arr_valid,
    output logic [N-1:0]    row_en,
    output logic [N*KW-1:0] row_k,
    output logic [N-1:0]    col_en,
    output logic [N*KW-1:0] col_k
);

    // Room for K + 2N without wrap even when K = 2^KW - 1.
    localparam int c_TW = KW + $clog2(2 * N) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_TW-1:0] r_t;
    logic [KW-1:0]   r_k;

    logic [c_TW-1:0] w_t_last;
    logic [c_TW-1:0] w_t_nxt;
    logic [N-1:0]    w_en_nxt;
    logic [N*KW-1:0] w_k_nxt;

    assign w_t_last = c_TW'(r_k) + c_TW'(2 * N - 3);
    assign w_t_nxt  = (r_state == S_FEED) ? r_t + c_TW'(1) : '0;

    // Lane i (row i and column i share timing) is live for i <= t < i+K.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic w_live;
            assign w_live = (w_t_nxt >= c_TW'(gi)) &&
                            ((w_t_nxt - c_TW'(gi)) < c_TW'(r_k));
            assign w_en_nxt[gi]          = w_live;
            assign w_k_nxt[gi*KW +: KW]  = w_live ? KW'(w_t_nxt - c_TW'(gi)) : '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_k        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            arr_nreset <= 1'b1;
            arr_valid  <= 1'b0;
            row_en     <= '0;
            row_k      <= '0;
            col_en     <= '0;
            col_k      <= '0;
        end else begin
            done       <= 1'b0;
            arr_nreset <= 1'b1;
            arr_valid  <= 1'b0;
            row_en     <= '0;
            row_k      <= '0;
            col_en     <= '0;
            col_k      <= '0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_k        <= k_len;
                        r_state    <= S_CLEAR;
                        busy       <= 1'b1;
                        arr_nreset <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_k == '0) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_t       <= '0;
                        r_state   <= S_FEED;
                        arr_valid <= 1'b1;
                        row_en    <= w_en_nxt;
                        row_k     <= w_k_nxt;
                        col_en    <= w_en_nxt;
                        col_k     <= w_k_nxt;
                    end
                end
                S_FEED: begin
                    if (r_t == w_t_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_t       <= w_t_nxt;
                        arr_valid <= 1'b1;
                        row_en    <= w_en_nxt;
                        row_k     <= w_k_nxt;
                        col_en    <= w_en_nxt;
                        col_k     <= w_k_nxt;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_seq_ctrl
// Purpose  : Directed bench for systolic_seq_ctrl with a behavioural 4x4 array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;

    logic            clock = 1'b0;
    logic            nreset;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy, done, arr_nreset, arr_valid;
    logic [N-1:0]    row_en, col_en;
    logic [N*KW-1:0] row_k, col_k;

    int n_cmp = 0;
    int n_err = 0;

    systolic_seq_ctrl #(.N(N), .KW(KW)) dut (
        .clock(clock), .nreset(nreset), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .arr_nreset(arr_nreset), .arr_valid(arr_valid),
        .row_en(row_en), .row_k(row_k), .col_en(col_en), .col_k(col_k)
    );

    always #5 clock = ~clock;

    // Behavioural array: A = identity, B[k][j] = k + j.
    int acc   [N][N];
    int a_reg [N][N];
    int b_reg [N][N];

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int a_l, b_t;
                if (j == 0) a_l = (row_en[i] && (int'(row_k[i*KW +: KW]) == i)) ? 1 : 0;
                else        a_l = a_reg[i][j-1];
                if (i == 0) b_t = col_en[j] ? int'(col_k[j*KW +: KW]) + j : 0;
                else        b_t = b_reg[i-1][j];
                if (!arr_nreset) begin
                    acc[i][j]   <= 0;
                    a_reg[i][j] <= 0;
                    b_reg[i][j] <= 0;
                end else begin
                    a_reg[i][j] <= a_l;
                    b_reg[i][j] <= b_t;
                    acc[i][j]   <= acc[i][j] + a_l * b_t;
                end
            end
        end
    end

    typedef struct {
        logic        busy;
        logic        done;
        logic        arn;
        logic        av;
        logic [3:0]  en;
        logic [31:0] k;
    } vec_t;

    vec_t tbl [1:14];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL wait_done: got timeout after %0d cycles expected done", cyc);
        end
    endtask

    task automatic chk_z(input string tag, input bit zero);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_z%0d%0d", tag, i, j), 64'(acc[i][j]), zero ? 64'd0 : 64'(i + j));
    endtask

    initial begin
        int cyc;
        int first_done, second_done, clears;
        bit saw_activity, saw_done;

        tbl[1]  = '{1, 0, 0, 0, 4'b0000, 32'h00000000};
        tbl[2]  = '{1, 0, 1, 1, 4'b0001, 32'h00000000};
        tbl[3]  = '{1, 0, 1, 1, 4'b0011, 32'h00000001};
        tbl[4]  = '{1, 0, 1, 1, 4'b0111, 32'h00000102};
        tbl[5]  = '{1, 0, 1, 1, 4'b1111, 32'h00010203};
        tbl[6]  = '{1, 0, 1, 1, 4'b1110, 32'h01020300};
        tbl[7]  = '{1, 0, 1, 1, 4'b1100, 32'h02030000};
        tbl[8]  = '{1, 0, 1, 1, 4'b1000, 32'h03000000};
        tbl[9]  = '{1, 0, 1, 1, 4'b0000, 32'h00000000};
        tbl[10] = '{1, 0, 1, 1, 4'b0000, 32'h00000000};
        tbl[11] = '{1, 0, 1, 1, 4'b0000, 32'h00000000};
        tbl[12] = '{1, 0, 1, 0, 4'b0000, 32'h00000000};
        tbl[13] = '{0, 1, 1, 0, 4'b0000, 32'h00000000};
        tbl[14] = '{0, 0, 1, 0, 4'b0000, 32'h00000000};

        // Reset held with start asserted
        nreset = 1'b0; start = 1'b1; k_len = 8'd4;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_arn", arr_nreset, 1);
        chk("rst_valid", arr_valid, 0);
        chk("rst_row_en", row_en, 0);
        chk("rst_col_en", col_en, 0);
        chk("rst_row_k", row_k, 0);
        chk("rst_col_k", col_k, 0);
        nreset = 1'b1;
        tick();
        chk("rel_busy", busy, 1);
        chk("rel_arn", arr_nreset, 0);
        start = 1'b0;
        wait_done(cyc);
        tick();

        // K=4 cycle-by-cycle table; k_len changes after acceptance
        start = 1'b1; k_len = 8'd4;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0;
                k_len = 8'd7;
            end
            chk($sformatf("k4_c%0d_busy", c), busy, tbl[c].busy);
            chk($sformatf("k4_c%0d_done", c), done, tbl[c].done);
            chk($sformatf("k4_c%0d_arn", c), arr_nreset, tbl[c].arn);
            chk($sformatf("k4_c%0d_valid", c), arr_valid, tbl[c].av);
            chk($sformatf("k4_c%0d_row_en", c), row_en, tbl[c].en);
            chk($sformatf("k4_c%0d_col_en", c), col_en, tbl[c].en);
            chk($sformatf("k4_c%0d_row_k", c), row_k, tbl[c].k);
            chk($sformatf("k4_c%0d_col_k", c), col_k, tbl[c].k);
            if (c == 13) chk_z("k4", 0);
        end

        // K=0: CLEAR then DONE, no feed activity, array zeroed
        start = 1'b1; k_len = 8'd0;
        saw_activity = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (arr_valid || row_en != 0 || col_en != 0) saw_activity = 1;
            if (c == 1) chk("k0_c1_arn", arr_nreset, 0);
            if (c == 2) chk("k0_c2_done", done, 1);
            if (c == 3) chk("k0_c3_done", done, 0);
        end
        chk("k0_no_feed", saw_activity, 0);
        chk_z("k0", 1);

        // start held high, K=2: period K+2N+2 = 12 cycles
        start = 1'b1; k_len = 8'd2;
        first_done = -1; second_done = -1; clears = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 23) start = 1'b0;
            if (done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (!arr_nreset) clears++;
            if (c == 24) chk("b2b_idle_busy", busy, 0);
            if (c == 25) chk("b2b_no_restart", busy, 0);
        end
        chk("b2b_first_done", 64'(first_done), 64'd11);
        chk("b2b_second_done", 64'(second_done), 64'd23);
        chk("b2b_clears", 64'(clears), 64'd2);

        // Reset during FEED at t=3, then a clean rerun
        start = 1'b1; k_len = 8'd4;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        chk("mid_row_en_t3", row_en, 4'b1111);
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", arr_valid, 0);
        chk("mid_row_en", row_en, 0);
        chk("mid_col_en", col_en, 0);
        saw_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done || busy) saw_done = 1;
        end
        chk("mid_quiet", saw_done, 0);
        start = 1'b1; k_len = 8'd4;
        tick();
        start = 1'b0;
        wait_done(cyc);
        chk("rerun_latency", 64'(cyc), 64'd12);
        chk_z("rerun", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
